// File: rtl/array_feeder_pkg.sv
// Shared types and constants for the host-side feeder of the 3x3 PE array.
package array_feeder_pkg;

  // Top-level phases: buffer a frame, replay it onto the array, gather results.
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    SEND    = 2'd1,
    COLLECT = 2'd2
  } feeder_state_t;

  // Header byte placed on readA in the first replay cycle.
  localparam logic [7:0] HDR = 8'hA5;

  // Number of filter taps that lead every frame.
  localparam int FILT_LEN = 9;

  // Bytes in one frame: the filter followed by the square ifmap.
  function automatic int frame_len(input int ifmap_w);
    return FILT_LEN + ifmap_w * ifmap_w;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small result FIFO. A push while full is still taken when a pop happens in
// the same cycle, since the head slot is vacated on that edge.
module result_fifo
  import array_feeder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // Head is forced to zero while empty so stale storage never leaks out.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (power of two).
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; occupancy tracking and the empty mask make its contents irrelevant.
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/array_feeder.sv
// Host-side feeder: buffers one frame from a byte stream, replays it
// gap-free onto the array buses, then captures the array's results into
// a small FIFO for the downstream consumer.
module array_feeder
  import array_feeder_pkg::*;
#(
  parameter int IFMAP_W    = 5,
  parameter int RESULT_LAT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] readA,
  output logic [7:0] readB,
  input  logic [7:0] write,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy,
  output logic       ovf
);

  localparam int FRAME_LEN = frame_len(IFMAP_W);
  localparam int OUT_W     = IFMAP_W - 2;
  localparam int COLL_LEN  = RESULT_LAT + OUT_W * OUT_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int COLL_W    = $clog2(COLL_LEN);

  localparam logic [CNT_W-1:0]  LAST_IDX     = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT    = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  FIRST_IFMAP  = CNT_W'(FILT_LEN + 1);
  localparam logic [COLL_W-1:0] LAST_COLL    = COLL_W'(COLL_LEN - 1);
  localparam logic [COLL_W-1:0] FIRST_SAMPLE = COLL_W'(RESULT_LAT);

  feeder_state_t     state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [COLL_W-1:0] coll_q, coll_d;
  logic [CNT_W-1:0]  rd_sel;
  logic [7:0]        read_a_q, read_a_d;
  logic [7:0]        read_b_q, read_b_d;
  logic              busy_q, busy_d;
  logic              ovf_q;
  logic [7:0]        frame_q [FRAME_LEN];

  logic              load_accept;
  logic              col_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              ovf_set;

  assign in_ready    = (state_q == LOAD);
  assign load_accept = in_valid & in_ready;
  assign res_valid   = ~fifo_empty;
  assign fifo_pop    = res_valid & res_ready;
  // A sample is lost only when the FIFO is full and nothing leaves this cycle.
  assign ovf_set     = col_push & fifo_full & ~fifo_pop;

  assign readA = read_a_q;
  assign readB = read_b_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;

  // FSM next-state: advance idx while loading, beat while sending, c while collecting.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    beat_d   = beat_q;
    coll_d   = coll_q;
    col_push = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (idx_q == LAST_IDX) begin
            state_d = SEND;
            idx_d   = '0;
            beat_d  = '0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      SEND: begin
        if (beat_q == LAST_BEAT) begin
          state_d = COLLECT;
          coll_d  = '0;
        end else begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      COLLECT: begin
        col_push = (coll_q >= FIRST_SAMPLE);
        if (coll_q == LAST_COLL) begin
          state_d = LOAD;
          idx_d   = '0;
        end else begin
          coll_d = coll_q + COLL_W'(1);
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
      end
    endcase
  end

  // Bus values for the coming cycle, decoded from next state and beat so the
  // array sees beat b during SEND cycle b. Filter and ifmap share one buffer,
  // so beat b (b >= 1) always reads buffer entry b-1.
  always_comb begin
    rd_sel   = (beat_d == '0) ? '0 : beat_d - CNT_W'(1);
    read_a_d = '0;
    read_b_d = '0;
    if (state_d == SEND) begin
      if (beat_d == '0) begin
        read_a_d = HDR;
      end else if (beat_d < FIRST_IFMAP) begin
        read_b_d = frame_q[rd_sel];
      end else begin
        read_a_d = frame_q[rd_sel];
      end
    end
    busy_d = (state_d != LOAD);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      beat_q   <= '0;
      coll_q   <= '0;
      read_a_q <= '0;
      read_b_q <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      beat_q   <= beat_d;
      coll_q   <= coll_d;
      read_a_q <= read_a_d;
      read_b_q <= read_b_d;
      busy_q   <= busy_d;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Frame buffer: each accepted byte lands at the current load index.
  always_ff @(posedge clk) begin
    if (load_accept) begin
      frame_q[idx_q] <= in_data;
    end
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_result_fifo (
    .clk     (clk),
    .rst_i   (RST),
    .push_i  (col_push),
    .data_i  (write),
    .pop_i   (fifo_pop),
    .data_o  (res_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_array_feeder.sv
// Directed bench for array_feeder: reset, nominal frame, upstream gaps,
// result backpressure, push/pop on a full FIFO, and reset during SEND.
module tb_array_feeder;

  localparam int FRAME_LEN = 34;
  localparam int SEND_LEN  = 35;
  localparam int COLL_LEN  = 13;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] readA;
  logic [7:0] readB;
  logic [7:0] write;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
  logic       ovf;

  always #5 clk = ~clk;

  array_feeder #(
    .IFMAP_W    (5),
    .RESULT_LAT (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .RST       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .readA     (readA),
    .readB     (readB),
    .write     (write),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] fr    [FRAME_LEN];
  logic [7:0] obs_a [SEND_LEN];
  logic [7:0] obs_b [SEND_LEN];
  logic       ovf_at [COLL_LEN];
  logic [7:0] pops [$];
  int         busy_bad, ready_bad, bus_bad, first_valid_c;
  logic       drain_busy0, drain_ready0;

  task automatic clear_obs();
    busy_bad      = 0;
    ready_bad     = 0;
    bus_bad       = 0;
    first_valid_c = -1;
    pops.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; write = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Frame A: filter 1..9, ifmap all 01.
  task automatic set_frame_a();
    for (int i = 0; i < FRAME_LEN; i++) fr[i] = (i < 9) ? 8'(i + 1) : 8'h01;
  endtask

  // Frame B: filter 9..1, ifmap 40..58.
  task automatic set_frame_b();
    for (int i = 0; i < FRAME_LEN; i++) fr[i] = (i < 9) ? 8'(9 - i) : 8'(8'h40 + i - 9);
  endtask

  task automatic load_frame(input bit gaps);
    int  i   = 0;
    bit  gap = gaps;
    res_ready = 1'b0;
    while (i < FRAME_LEN) begin
      @(negedge clk);
      if (in_ready !== 1'b1) ready_bad++;
      if (busy !== 1'b0) busy_bad++;
      if (gap) begin
        in_valid = 1'b0; in_data = 8'hCC;
      end else begin
        in_valid = 1'b1; in_data = fr[i]; i++;
      end
      if (gaps) gap = ~gap;
    end
  endtask

  task automatic observe_send(input int n);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h5A;   // must be ignored outside LOAD
      obs_a[b] = readA;
      obs_b[b] = readB;
      if (busy !== 1'b1) busy_bad++;
      if (in_ready !== 1'b0) ready_bad++;
    end
  endtask

  // Array model: returns 10,11,.. from COLLECT cycle 4; junk before that.
  task automatic observe_collect(input int rr_start);
    for (int c = 0; c < COLL_LEN; c++) begin
      @(negedge clk);
      write = (c >= 4) ? 8'(8'h10 + c - 4) : 8'hEE;
      if (busy !== 1'b1) busy_bad++;
      if (in_ready !== 1'b0) ready_bad++;
      if (readA !== 8'h00 || readB !== 8'h00) bus_bad++;
      ovf_at[c] = ovf;
      if (res_valid === 1'b1 && first_valid_c < 0) first_valid_c = c;
      res_ready = (c >= rr_start);
      if (res_valid === 1'b1 && res_ready) pops.push_back(res_data);
    end
  endtask

  task automatic drain(input int n, input bit rr);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0; write = 8'hEE; res_ready = rr;
      if (k == 0) begin drain_busy0 = busy; drain_ready0 = in_ready; end
      if (res_valid === 1'b1 && res_ready) pops.push_back(res_data);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; res_ready = 1'b1; write = 8'h33;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (readA !== 8'h00)     begin errors++; $display("FAIL reset_readA: got %h expected 00", readA); end
    checks++; if (readB !== 8'h00)     begin errors++; $display("FAIL reset_readB: got %h expected 00", readB); end
    checks++; if (res_data !== 8'h00)  begin errors++; $display("FAIL reset_res_data: got %h expected 00", res_data); end
    checks++; if (res_valid !== 1'b0)  begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ovf !== 1'b0)        begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
  endtask

  task automatic test_nominal();
    logic [7:0] ea, eb;
    set_frame_a();
    clear_obs();
    load_frame(1'b0);
    observe_send(SEND_LEN);
    observe_collect(0);
    drain(3, 1'b1);
    for (int b = 0; b < SEND_LEN; b++) begin
      ea = (b == 0) ? 8'hA5 : ((b < 10) ? 8'h00 : 8'h01);
      eb = (b >= 1 && b <= 9) ? 8'(b) : 8'h00;
      checks++; if (obs_a[b] !== ea) begin errors++; $display("FAIL nominal_readA[%0d]: got %h expected %h", b, obs_a[b], ea); end
      checks++; if (obs_b[b] !== eb) begin errors++; $display("FAIL nominal_readB[%0d]: got %h expected %h", b, obs_b[b], eb); end
    end
    checks++; if (busy_bad != 0)      begin errors++; $display("FAIL nominal_busy: %0d bad cycles, expected 0", busy_bad); end
    checks++; if (ready_bad != 0)     begin errors++; $display("FAIL nominal_in_ready: %0d bad cycles, expected 0", ready_bad); end
    checks++; if (bus_bad != 0)       begin errors++; $display("FAIL nominal_collect_bus: %0d nonzero cycles, expected 0", bus_bad); end
    checks++; if (first_valid_c != 5) begin errors++; $display("FAIL nominal_first_valid: got cycle %0d expected 5", first_valid_c); end
    checks++; if (drain_busy0 !== 1'b0 || drain_ready0 !== 1'b1)
      begin errors++; $display("FAIL nominal_load_reentry: busy %b in_ready %b expected 0 1", drain_busy0, drain_ready0); end
    checks++; if (pops.size() != 9)   begin errors++; $display("FAIL nominal_pop_count: got %0d expected 9", pops.size()); end
    for (int i = 0; i < pops.size() && i < 9; i++) begin
      checks++; if (pops[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL nominal_pop[%0d]: got %h expected %h", i, pops[i], 8'(8'h10 + i)); end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL nominal_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_gaps();
    logic [7:0] ea, eb;
    set_frame_a();
    clear_obs();
    load_frame(1'b1);
    observe_send(SEND_LEN);
    observe_collect(0);
    drain(3, 1'b1);
    for (int b = 0; b < SEND_LEN; b++) begin
      ea = (b == 0) ? 8'hA5 : ((b < 10) ? 8'h00 : 8'h01);
      eb = (b >= 1 && b <= 9) ? 8'(b) : 8'h00;
      checks++; if (obs_a[b] !== ea) begin errors++; $display("FAIL gaps_readA[%0d]: got %h expected %h", b, obs_a[b], ea); end
      checks++; if (obs_b[b] !== eb) begin errors++; $display("FAIL gaps_readB[%0d]: got %h expected %h", b, obs_b[b], eb); end
    end
    checks++; if (busy_bad != 0)  begin errors++; $display("FAIL gaps_busy: %0d bad cycles, expected 0", busy_bad); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL gaps_in_ready: %0d bad cycles, expected 0", ready_bad); end
    checks++; if (bus_bad != 0)   begin errors++; $display("FAIL gaps_collect_bus: %0d nonzero cycles, expected 0", bus_bad); end
    checks++; if (pops.size() != 9) begin errors++; $display("FAIL gaps_pop_count: got %0d expected 9", pops.size()); end
  endtask

  task automatic test_backpressure();
    set_frame_a();
    clear_obs();
    load_frame(1'b0);
    observe_send(SEND_LEN);
    observe_collect(99);
    checks++; if (ovf_at[8] !== 1'b0) begin errors++; $display("FAIL bp_ovf_before_drop: got %b expected 0", ovf_at[8]); end
    checks++; if (ovf_at[9] !== 1'b1) begin errors++; $display("FAIL bp_ovf_after_drop: got %b expected 1", ovf_at[9]); end
    checks++; if (pops.size() != 0)   begin errors++; $display("FAIL bp_no_pops: got %0d expected 0", pops.size()); end
    drain(6, 1'b1);
    checks++; if (pops.size() != 4)   begin errors++; $display("FAIL bp_pop_count: got %0d expected 4", pops.size()); end
    for (int i = 0; i < pops.size() && i < 4; i++) begin
      checks++; if (pops[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL bp_pop[%0d]: got %h expected %h", i, pops[i], 8'(8'h10 + i)); end
    end
    checks++; if (ovf !== 1'b1)       begin errors++; $display("FAIL bp_ovf_sticky: got %b expected 1", ovf); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_after: got %b expected 0", res_valid); end
  endtask

  task automatic test_push_pop_full();
    apply_reset();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ppf_ovf_cleared: got %b expected 0", ovf); end
    set_frame_a();
    clear_obs();
    load_frame(1'b0);
    observe_send(SEND_LEN);
    observe_collect(8);   // four samples fill the FIFO, then pop from the 5th sample on
    drain(6, 1'b1);
    checks++; if (ovf_at[12] !== 1'b0) begin errors++; $display("FAIL ppf_ovf_collect: got %b expected 0", ovf_at[12]); end
    checks++; if (ovf !== 1'b0)        begin errors++; $display("FAIL ppf_ovf_end: got %b expected 0", ovf); end
    checks++; if (pops.size() != 9)    begin errors++; $display("FAIL ppf_pop_count: got %0d expected 9", pops.size()); end
    for (int i = 0; i < pops.size() && i < 9; i++) begin
      checks++; if (pops[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL ppf_pop[%0d]: got %h expected %h", i, pops[i], 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] ea, eb;
    set_frame_b();
    clear_obs();
    load_frame(1'b0);
    observe_send(13);
    checks++; if (obs_a[12] !== 8'h42) begin errors++; $display("FAIL mid_beat12_readA: got %h expected 42", obs_a[12]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (readA !== 8'h00 || readB !== 8'h00)
      begin errors++; $display("FAIL mid_reset_bus: readA %h readB %h expected 00 00", readA, readB); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    clear_obs();
    load_frame(1'b0);
    observe_send(SEND_LEN);
    observe_collect(0);
    drain(3, 1'b1);
    for (int b = 0; b < SEND_LEN; b++) begin
      ea = (b == 0) ? 8'hA5 : ((b < 10) ? 8'h00 : 8'(8'h40 + b - 10));
      eb = (b >= 1 && b <= 9) ? 8'(10 - b) : 8'h00;
      checks++; if (obs_a[b] !== ea) begin errors++; $display("FAIL mid_readA[%0d]: got %h expected %h", b, obs_a[b], ea); end
      checks++; if (obs_b[b] !== eb) begin errors++; $display("FAIL mid_readB[%0d]: got %h expected %h", b, obs_b[b], eb); end
    end
    checks++; if (pops.size() != 9) begin errors++; $display("FAIL mid_pop_count: got %0d expected 9", pops.size()); end
    for (int i = 0; i < pops.size() && i < 9; i++) begin
      checks++; if (pops[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL mid_pop[%0d]: got %h expected %h", i, pops[i], 8'(8'h10 + i)); end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", ovf); end
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; res_ready = 1'b0; write = 8'h00;
    test_reset();
    test_nominal();
    test_gaps();
    test_backpressure();
    test_push_pop_full();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_feeder.md
# array_feeder

Host-side driver for the 3x3 PE convolution array. Accepts one frame (3x3 filter plus IFMAP_W x IFMAP_W ifmap) from an upstream byte stream with valid/ready, buffers it, then replays it gap-free onto the array's `readA`/`readB` byte buses. It captures the array's saturated `write` results in a fixed window and returns them through a small result FIFO with valid/ready. It sits between the chip-level I/O adapter and the array top.

## Interface
- `IFMAP_W`, 5: ifmap side length; output side length is `IFMAP_W-2`.
- `RESULT_LAT`, 4: cycles from the last SEND beat to the first valid `write` sample.
- `FIFO_DEPTH`, 4: result FIFO entries, power of two.
- `clk`  in  1  the single clock; all logic is rising-edge.
- `RST`  in  1  synchronous, active-high reset.
- `in_data`  in  8  frame byte from upstream.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `readA`  out  8  ifmap/header bus to the array.
- `readB`  out  8  filter bus to the array.
- `write`  in  8  saturated signed result byte from the array.
- `res_data`  out  8  head of the result FIFO.
- `res_valid`  out  1  FIFO is non-empty.
- `res_ready`  in  1  downstream pops the head.
- `busy`  out  1  high in SEND and COLLECT.
- `ovf`  out  1  sticky flag: a result sample was dropped.

## Operation
- Frame: FRAME_LEN = 9 + IFMAP_W² bytes. Filter row-major comes first, then ifmap row-major. The default frame is 34 bytes.
- States: LOAD, SEND, COLLECT.
- **LOAD**
  - `in_ready` = 1.
  - Each `in_valid & in_ready` beat writes the byte into buffer[idx] and increments idx.
  - The accepting beat at idx = FRAME_LEN-1 moves to SEND next cycle.
- **SEND**: lasts 1 + FRAME_LEN cycles, beat counter b = 0..FRAME_LEN.
  - b = 0: `readA` = HDR (8'hA5), `readB` = 0.
  - b = 1..9: `readA` = 0, `readB` = filter[b-1].
  - b = 10..FRAME_LEN: `readA` = ifmap[b-10], `readB` = 0.
  - After the last beat, go to COLLECT.
- **COLLECT**: lasts RESULT_LAT + (IFMAP_W-2)² cycles.
  - `readA` = `readB` = 0.
  - Cycles c ≥ RESULT_LAT sample `write` as one push.
  - After the last cycle, go to LOAD with idx = 0.
- In all states other than SEND, `readA` = `readB` = 0.
- FIFO push rule:
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped and `ovf` is set. `ovf` is cleared only by `RST`.
- FIFO pop: `res_valid & res_ready`. Pops are allowed in any state.
- The FIFO is first-in first-out. Pointers wrap modulo FIFO_DEPTH. A separate count distinguishes full from empty.
- The buffer is not cleared between frames; it is fully overwritten by the next LOAD.
- Reset, whether idle or mid-operation, returns to LOAD with:
  - idx = 0, FIFO empty, `ovf` = 0.
  - Any partially loaded frame discarded.

## Timing
- Reset values: `in_ready` = 1, `readA` = 0, `readB` = 0, `res_data` = 0, `res_valid` = 0, `busy` = 0, `ovf` = 0.
- All outputs are registered except `in_ready`, `res_valid` and `res_data`, which decode from the state register and FIFO registers.
- Upstream gaps (`in_valid` low) stall only LOAD. The SEND stream is always contiguous, exactly 1 + FRAME_LEN cycles.
- `readA`/`readB` for beat b are driven in SEND cycle b (registered from state and counter). The array therefore sees the header on the first SEND cycle.
- The first result sample is taken at COLLECT cycle RESULT_LAT. With the default parameters, that is 4 cycles after COLLECT entry. It appears on `res_data` with `res_valid` = 1 one cycle later.
- Frame-to-frame latency is FRAME_LEN accepted beats plus 35 + 13 = 48 cycles. `in_ready` is low for those 48 cycles.
- `busy` rises on the cycle SEND is entered and falls on the cycle LOAD is re-entered.

## Structure
- `array_feeder_pkg` holds:
  - the state enum `feeder_state_t` (LOAD, SEND, COLLECT);
  - constants HDR = 8'hA5, FILT_LEN = 9, and the function `frame_len(IFMAP_W)`.
- Sub-module `result_fifo` (DEPTH, width 8) provides push/pop/full/empty/count. It implements the simultaneous push-on-full-with-pop rule.
- The top contains the frame buffer, the idx/beat/collect counters and the FSM.

## Test plan
- **Reset:** assert `RST` 2 cycles → all outputs at reset values; `in_ready` = 1.
- **Nominal frame:**
  - Stimulus: filter 1..9, ifmap all 8'h01, array model returning 8'h10..8'h18 from COLLECT cycle 4.
  - Required: `readA` sees A5 and then nine 00s; `readB` sees 00 and then 01..09; `readA` then sees twenty-five 01s.
  - Required: `res_data` pops 10..18 in order; `ovf` = 0.
- **Upstream gaps:** `in_valid` toggles every other cycle during LOAD → SEND is still exactly 35 contiguous beats with identical bus values.
- **Backpressure:** `res_ready` held low → 4 results buffered (10..13) and `ovf` = 1 after the 5th sample. Then releasing `res_ready` pops 10..13 only.
- **Simultaneous push/pop on full:** FIFO full and `res_ready` = 1 on a sample cycle → push is accepted, `ovf` stays 0, order is preserved.
- **Reset mid-SEND:** assert `RST` at beat 12 → next cycle `readA` = `readB` = 0, `busy` = 0, `in_ready` = 1. A new full frame then completes normally.
